// File: rtl/vga_sync_rx_if.sv
// VGA receive-side bundle: the sampled sync/colour lines plus the recovered
// coordinates, pixel and timing status.
interface vga_sync_rx_if;
   logic       hsync;
   logic       vsync;
   logic [2:0] red;
   logic [2:0] green;
   logic [1:0] blue;
   logic [9:0] x;
   logic [9:0] y;
   logic       pix_valid;
   logic [7:0] pixel;
   logic       locked;
   logic       frame_start;
   logic       err_hlen;
   logic       err_vlen;
   logic [15:0] good_frames;

   // master: the VGA source / bench side; slave: the receiver
   modport master (
      output hsync, vsync, red, green, blue,
      input  x, y, pix_valid, pixel, locked, frame_start, err_hlen, err_vlen, good_frames
   );
   modport slave (
      input  hsync, vsync, red, green, blue,
      output x, y, pix_valid, pixel, locked, frame_start, err_hlen, err_vlen, good_frames
   );
endinterface

// File: rtl/vga_sync_rx.sv
// VGA timing receiver: locks onto hsync/vsync, recovers x/y/pixel, flags
// line/frame length violations and counts clean frames.
module vga_sync_rx #(
   parameter int H_TOTAL = 800,
   parameter int H_SYNC  = 96,
   parameter int H_BP    = 144,
   parameter int H_FP    = 784,
   parameter int V_TOTAL = 521,
   parameter int V_SYNC  = 2,
   parameter int V_BP    = 31,
   parameter int V_FP    = 511
) (
   input logic           dclk,
   input logic           clr,
   vga_sync_rx_if.slave  bus
);
   localparam logic [10:0] H_TOT_W  = 11'(H_TOTAL);
   localparam logic [10:0] H_MAX_W  = 11'(2 * H_TOTAL);
   localparam logic [10:0] H_SYNC_W = 11'(H_SYNC);
   localparam logic [10:0] H_BP_W   = 11'(H_BP);
   localparam logic [10:0] H_FP_W   = 11'(H_FP);
   localparam logic [9:0]  V_TOT_W  = 10'(V_TOTAL);
   localparam logic [9:0]  V_LAST_W = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_SYNC_W = 10'(V_SYNC);
   localparam logic [9:0]  V_BP_W   = 10'(V_BP);
   localparam logic [9:0]  V_FP_W   = 10'(V_FP);

   typedef enum logic [1:0] {SEARCH, LINE, VWAIT, LOCKED} state_t;

   state_t      state_q, state_d;
   logic        hs_prev_q, vs_prev_q;
   logic [10:0] h_q, h_d, h_inc;
   logic [9:0]  v_q, v_d, v_inc;
   logic [1:0]  good_lines_q, good_lines_d;
   logic [9:0]  x_q, x_d, y_q, y_d;
   logic [7:0]  pixel_q, pixel_d;
   logic        pix_valid_q, pix_valid_d;
   logic        locked_q, locked_d;
   logic        frame_start_q, frame_start_d;
   logic        err_hlen_q, err_hlen_d;
   logic        err_vlen_q, err_vlen_d;
   logic [15:0] good_frames_q, good_frames_d;
   logic        hs_fall, hs_rise, vs_fall, vs_rise;

   always_comb begin
      hs_fall = !bus.hsync && hs_prev_q;
      hs_rise = bus.hsync && !hs_prev_q;
      vs_fall = !bus.vsync && vs_prev_q;
      vs_rise = bus.vsync && !vs_prev_q;
      // h_inc is what h would read on this sample if no fall restarted it
      h_inc = (h_q == H_MAX_W) ? h_q : h_q + 11'd1;
      v_inc = (v_q == V_TOT_W) ? v_q : v_q + 10'd1;

      state_d       = state_q;
      h_d           = hs_fall ? 11'd0 : h_inc;
      v_d           = hs_fall ? v_inc : v_q;
      good_lines_d  = good_lines_q;
      frame_start_d = 1'b0;
      err_hlen_d    = 1'b0;
      err_vlen_d    = 1'b0;
      good_frames_d = good_frames_q;

      case (state_q)
         SEARCH: begin
            good_lines_d = 2'd0;
            if (hs_fall) state_d = LINE;
         end
         LINE, VWAIT: begin
            if (hs_fall) begin
               if (h_inc != H_TOT_W) begin
                  good_lines_d = 2'd0;
                  state_d      = LINE;
               end else if (state_q == VWAIT && vs_fall) begin
                  state_d       = LOCKED;
                  v_d           = 10'd0;
                  frame_start_d = 1'b1;
               end else if (state_q == LINE) begin
                  good_lines_d = good_lines_q + 2'd1;
                  if (good_lines_q == 2'd1) state_d = VWAIT;
               end
            end else if (h_inc == H_MAX_W) begin
               good_lines_d = 2'd0;
               state_d      = LINE;
            end
         end
         LOCKED: begin
            err_hlen_d = (hs_fall && h_inc != H_TOT_W) ||
                         (!hs_fall && h_inc == H_TOT_W) ||
                         (hs_rise && h_inc != H_SYNC_W);
            err_vlen_d = (vs_fall && !hs_fall) ||
                         (vs_fall && hs_fall && v_q != V_LAST_W) ||
                         (hs_fall && !vs_fall && v_inc == V_TOT_W) ||
                         (vs_rise && !(hs_fall && v_inc == V_SYNC_W));
            if (err_hlen_d || err_vlen_d) begin
               state_d      = SEARCH;
               good_lines_d = 2'd0;
            end else if (hs_fall && vs_fall) begin
               v_d           = 10'd0;
               frame_start_d = 1'b1;
               good_frames_d = (good_frames_q == 16'hFFFF) ? good_frames_q : good_frames_q + 16'd1;
            end
         end
         default: state_d = SEARCH;
      endcase

      // locked covers both the entry sample and the sample that raises an error
      locked_d    = (state_q == LOCKED) || (state_d == LOCKED);
      pix_valid_d = locked_d && h_d >= H_BP_W && h_d < H_FP_W && v_d >= V_BP_W && v_d < V_FP_W;
      x_d         = pix_valid_d ? 10'(h_d - H_BP_W) : x_q;
      y_d         = pix_valid_d ? v_d - V_BP_W : y_q;
      pixel_d     = pix_valid_d ? {bus.red, bus.green, bus.blue} : pixel_q;
   end

   always_ff @(posedge dclk) begin
      if (clr) begin
         state_q       <= SEARCH;
         hs_prev_q     <= 1'b1;
         vs_prev_q     <= 1'b1;
         h_q           <= 11'd0;
         v_q           <= 10'd0;
         good_lines_q  <= 2'd0;
         x_q           <= 10'd0;
         y_q           <= 10'd0;
         pixel_q       <= 8'd0;
         pix_valid_q   <= 1'b0;
         locked_q      <= 1'b0;
         frame_start_q <= 1'b0;
         err_hlen_q    <= 1'b0;
         err_vlen_q    <= 1'b0;
         good_frames_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         hs_prev_q     <= bus.hsync;
         vs_prev_q     <= bus.vsync;
         h_q           <= h_d;
         v_q           <= v_d;
         good_lines_q  <= good_lines_d;
         x_q           <= x_d;
         y_q           <= y_d;
         pixel_q       <= pixel_d;
         pix_valid_q   <= pix_valid_d;
         locked_q      <= locked_d;
         frame_start_q <= frame_start_d;
         err_hlen_q    <= err_hlen_d;
         err_vlen_q    <= err_vlen_d;
         good_frames_q <= good_frames_d;
      end
   end

   assign bus.x           = x_q;
   assign bus.y           = y_q;
   assign bus.pixel       = pixel_q;
   assign bus.pix_valid   = pix_valid_q;
   assign bus.locked      = locked_q;
   assign bus.frame_start = frame_start_q;
   assign bus.err_hlen    = err_hlen_q;
   assign bus.err_vlen    = err_vlen_q;
   assign bus.good_frames = good_frames_q;
endmodule

// File: tb/tb_vga_sync_rx.sv
// Scoreboard bench for vga_sync_rx on a scaled-down 20x12 timing: stimulus
// queues expected events, a negedge monitor pops them as the DUT emits them.
module tb_vga_sync_rx;
   localparam int H_TOTAL = 20;
   localparam int H_SYNC  = 3;
   localparam int H_BP    = 5;
   localparam int H_FP    = 17;
   localparam int V_TOTAL = 12;
   localparam int V_SYNC  = 2;
   localparam int V_BP    = 3;
   localparam int V_FP    = 10;

   typedef struct {
      int          tag;
      bit          pv;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [7:0]  pix;
      bit          fs;
      bit          eh;
      bit          ev;
      bit          lk;
      logic [15:0] gf;
   } exp_t;

   logic dclk = 1'b0;
   logic clr  = 1'b1;
   vga_sync_rx_if bus ();

   vga_sync_rx #(
      .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_FP(H_FP),
      .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_FP(V_FP)
   ) dut (
      .dclk (dclk),
      .clr  (clr),
      .bus  (bus)
   );

   always #5 dclk = ~dclk;

   int          edge_n = 0;
   int          checks = 0;
   int          errors = 0;
   exp_t        q[$];
   exp_t        mon_e;
   bit          exp_lock = 1'b0;
   logic [15:0] exp_gf = 16'd0;
   int          pend_unlock = 0;
   int          pend_rst = 0;
   int          g_short_v = -1;
   int          g_narrow_v = -1;
   int          g_clr_v = -1;
   int          g_clr_h = -1;

   always @(posedge dclk) edge_n <= edge_n + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, edge_n, act, exp);
      end
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, ".x"},           32'(bus.x), 0);
      chk({tag, ".y"},           32'(bus.y), 0);
      chk({tag, ".pix_valid"},   32'(bus.pix_valid), 0);
      chk({tag, ".pixel"},       32'(bus.pixel), 0);
      chk({tag, ".locked"},      32'(bus.locked), 0);
      chk({tag, ".frame_start"}, 32'(bus.frame_start), 0);
      chk({tag, ".err_hlen"},    32'(bus.err_hlen), 0);
      chk({tag, ".err_vlen"},    32'(bus.err_vlen), 0);
      chk({tag, ".good_frames"}, 32'(bus.good_frames), 0);
   endtask

   // Monitor: every emitted event must match the oldest queued expectation.
   always @(negedge dclk) begin
      if (bus.pix_valid || bus.frame_start || bus.err_hlen || bus.err_vlen) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event at edge %0d: pv=%b fs=%b eh=%b ev=%b x=%0d y=%0d",
                     edge_n, bus.pix_valid, bus.frame_start, bus.err_hlen, bus.err_vlen, bus.x, bus.y);
         end else begin
            mon_e = q.pop_front();
            if (mon_e.tag != edge_n || mon_e.pv != bus.pix_valid || mon_e.fs != bus.frame_start ||
                mon_e.eh != bus.err_hlen || mon_e.ev != bus.err_vlen || mon_e.lk != bus.locked ||
                mon_e.gf != bus.good_frames ||
                (mon_e.pv && (mon_e.x != bus.x || mon_e.y != bus.y || mon_e.pix != bus.pixel))) begin
               errors++;
               $display("FAIL event got edge=%0d pv=%b x=%0d y=%0d pix=%0d fs=%b eh=%b ev=%b lk=%b gf=%0d, expected edge=%0d pv=%b x=%0d y=%0d pix=%0d fs=%b eh=%b ev=%b lk=%b gf=%0d",
                        edge_n, bus.pix_valid, bus.x, bus.y, bus.pixel, bus.frame_start, bus.err_hlen,
                        bus.err_vlen, bus.locked, bus.good_frames, mon_e.tag, mon_e.pv, mon_e.x, mon_e.y,
                        mon_e.pix, mon_e.fs, mon_e.eh, mon_e.ev, mon_e.lk, mon_e.gf);
            end
         end
      end
   end

   task automatic step();
      @(negedge dclk);
      if (pend_unlock > 0) begin
         pend_unlock--;
         if (pend_unlock == 0) chk("locked_after_err", 32'(bus.locked), 0);
      end
      if (pend_rst > 0) begin
         pend_rst--;
         if (pend_rst == 0) chk_rst("mid_clr");
      end
   endtask

   // One frame of nl lines; fs/cnt/ev0 describe what the first sample should produce.
   task automatic drive_frame(input int nl, input bit fs, input bit cnt, input bit ev0);
      exp_t       e;
      int         len;
      int         hsw;
      bit         c;
      logic [7:0] rgb;
      for (int v = 0; v < nl; v++) begin
         len = (v == g_short_v) ? H_TOTAL - 1 : H_TOTAL;
         hsw = (v == g_narrow_v) ? H_SYNC - 1 : H_SYNC;
         for (int h = 0; h < len; h++) begin
            step();
            c = (v == g_clr_v) && (h == g_clr_h);
            e.tag = edge_n + 1;
            e.fs  = 1'b0;
            if (c) begin
               exp_lock = 1'b0;
               exp_gf   = 16'd0;
               pend_rst = 1;
            end else begin
               if (v == 0 && h == 0 && fs) begin
                  if (cnt) exp_gf++;
                  exp_lock = 1'b1;
                  e.fs = 1'b1;
               end
               e.ev  = (v == 0 && h == 0 && ev0);
               e.eh  = (g_short_v >= 0 && v == g_short_v + 1 && h == 0) ||
                       (v == g_narrow_v && h == H_SYNC - 1);
               e.pv  = exp_lock && h >= H_BP && h < H_FP && v >= V_BP && v < V_FP;
               e.x   = 10'(h - H_BP);
               e.y   = 10'(v - V_BP);
               e.pix = 8'(h);
               e.lk  = exp_lock;
               e.gf  = exp_gf;
               if (e.pv || e.fs || e.eh || e.ev) q.push_back(e);
               if (e.eh || e.ev) begin
                  exp_lock    = 1'b0;
                  pend_unlock = 2;
               end
            end
            rgb       = 8'(h);
            bus.hsync = (h >= hsw);
            bus.vsync = (v >= V_SYNC);
            bus.red   = rgb[7:5];
            bus.green = rgb[4:2];
            bus.blue  = rgb[1:0];
            clr       = c;
         end
      end
   endtask

   initial begin
      bus.hsync = 1'b1;
      bus.vsync = 1'b1;
      bus.red   = '0;
      bus.green = '0;
      bus.blue  = '0;
      clr       = 1'b1;
      repeat (3) step();
      chk_rst("reset");

      // acquire from reset, then three clean locked frames
      drive_frame(V_TOTAL, 1'b0, 1'b0, 1'b0);
      drive_frame(V_TOTAL, 1'b1, 1'b0, 1'b0);
      drive_frame(V_TOTAL, 1'b1, 1'b1, 1'b0);
      drive_frame(V_TOTAL, 1'b1, 1'b1, 1'b0);
      drive_frame(V_TOTAL, 1'b1, 1'b1, 1'b0);

      // one short line, then re-lock at the next frame
      g_short_v = 5;
      drive_frame(V_TOTAL, 1'b1, 1'b1, 1'b0);
      g_short_v = -1;
      drive_frame(V_TOTAL, 1'b1, 1'b0, 1'b0);

      // frame one line short: vsync falls early
      drive_frame(V_TOTAL - 1, 1'b1, 1'b1, 1'b0);
      drive_frame(V_TOTAL, 1'b0, 1'b0, 1'b1);
      drive_frame(V_TOTAL, 1'b1, 1'b0, 1'b0);

      // hsync pulse one clock narrow
      g_narrow_v = 4;
      drive_frame(V_TOTAL, 1'b1, 1'b1, 1'b0);
      g_narrow_v = -1;
      drive_frame(V_TOTAL, 1'b1, 1'b0, 1'b0);

      // one-cycle clr in the active region of a locked frame
      g_clr_v = 5;
      g_clr_h = 10;
      drive_frame(V_TOTAL, 1'b1, 1'b1, 1'b0);
      g_clr_v = -1;
      g_clr_h = -1;
      drive_frame(V_TOTAL, 1'b1, 1'b0, 1'b0);
      drive_frame(V_TOTAL, 1'b1, 1'b1, 1'b0);
      drive_frame(1, 1'b1, 1'b1, 1'b0);

      @(negedge dclk);
      #1;
      chk("final_good_frames", 32'(bus.good_frames), 32'(exp_gf));
      while (q.size() > 0) begin
         mon_e = q.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_event: expected at edge %0d pv=%b fs=%b eh=%b ev=%b, got nothing",
                  mon_e.tag, mon_e.pv, mon_e.fs, mon_e.eh, mon_e.ev);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/vga_sync_rx.md
Name: vga_sync_rx

Overview:
- Receiving end of the 640x480 VGA interface. Samples hsync/vsync/RGB on the pixel clock, locks onto the timing, and recovers pixel coordinates and colour.
- Used as an on-chip / bench monitor of the VGA controller output, so the frame can be checked pixel-by-pixel.
- Flags line-length and frame-length timing violations, and counts good frames.

Parameters:
- H_TOTAL, 800, pixel clocks per line
- H_SYNC, 96, hsync low width in clocks
- H_BP, 144, first visible h count
- H_FP, 784, first non-visible h count after the active region
- V_TOTAL, 521, lines per frame
- V_SYNC, 2, vsync low width in lines
- V_BP, 31, first visible line
- V_FP, 511, first non-visible line after the active region

Ports:
- dclk  in  1  pixel clock (25 MHz)
- clr  in  1  synchronous active-high reset
- hsync  in  1  active-low horizontal sync
- vsync  in  1  active-low vertical sync
- red  in  3  red sample
- green  in  3  green sample
- blue  in  2  blue sample
- x  out  10  visible column, 0..639
- y  out  10  visible row, 0..479
- pix_valid  out  1  x/y/pixel describe a visible pixel
- pixel  out  8  {red,green,blue} registered with x/y
- locked  out  1  timing locked
- frame_start  out  1  one-cycle pulse at each locked frame start
- err_hlen  out  1  one-cycle pulse: line timing violation
- err_vlen  out  1  one-cycle pulse: frame timing violation
- good_frames  out  16  saturating count of complete error-free frames

Behaviour:
- Counting and latency
  - All logic on posedge dclk. clr is synchronous and overrides everything.
  - A falling edge means the input is sampled 0 while its previous sample was 1. The previous-sample registers reset to 1.
  - Internal h counter: the sample on which hsync first reads low has h=0; h increments by 1 per clock.
  - Internal v counter increments on every hsync falling edge.
  - Outputs are registered: they reflect the sample taken on the previous dclk edge (latency 1).
- Reset: x=0, y=0, pix_valid=0, pixel=0, locked=0, frame_start=0, err_hlen=0, err_vlen=0, good_frames=0, state=SEARCH, h=0, v=0, good_lines=0.
- FSM
  - SEARCH: wait for an hsync fall, then go to LINE with h=0.
  - LINE: on each hsync fall, a line is good if its length equals H_TOTAL.
    - Good line: good_lines++. When good_lines reaches 2, go to VWAIT.
    - Bad line: good_lines=0; stay in LINE. A line also counts as bad if h reaches 2*H_TOTAL with no fall.
  - VWAIT: wait for a vsync fall sampled on the same cycle as an hsync fall. Then go to LOCKED with v=0, h=0 and pulse frame_start.
    - A vsync fall on any other cycle is ignored.
    - Lines keep being checked as in LINE. A bad line returns to LINE with good_lines=0.
  - LOCKED: locked=1.
    - err_hlen, then SEARCH: hsync fall at h != H_TOTAL-1+1 (i.e. line length != H_TOTAL), h reaching H_TOTAL with no fall, or hsync rising at h != H_SYNC.
    - err_vlen, then SEARCH: vsync fall not coincident with an hsync fall, a coincident vsync fall when the previous v != V_TOTAL-1, v reaching V_TOTAL without a vsync fall, or vsync rising at any point other than the hsync fall where v becomes V_SYNC.
    - Valid vsync fall: v=0, frame_start pulse. good_frames++ (saturating at 16'hFFFF) if the frame just ended was fully checked in LOCKED.
- Error precedence: if both errors fire on the same cycle, both pulses assert, then one transition to SEARCH.
- Exit from LOCKED: on any error, locked drops the cycle after the pulse and good_lines clears. good_frames holds its value; only clr clears it.
- Active region
  - pix_valid=1 iff locked, H_BP<=h<H_FP and V_BP<=v<V_FP.
  - x=h-H_BP and y=v-V_BP (10-bit); pixel={red,green,blue}.
  - When pix_valid=0, x, y and pixel hold their last values.
- Mid-operation clr: all state and outputs return to reset values on the next edge. An in-progress frame is not counted.
- All comparisons use 11-bit h and 10-bit v, with no wrap. The counters stop at 2*H_TOTAL and V_TOTAL when in error.

Test Plan:
- Ideal 800x521 timing from reset: locked asserts after 2 full lines plus the wait for the next frame start (at most 1 frame + 3 lines). First frame_start coincides with the lock. First pix_valid has x=0,y=0 at h=144,v=31. Last has x=639,y=479. There are 307200 valid pixels per frame. good_frames=3 after 3 further frames.
- Drive RGB=h[7:0] on a locked stream: pixel==x+144 (mod 256) on every valid cycle; no valid pixel outside the active region.
- After lock, one line of 799 clocks: err_hlen pulses exactly once, locked=0, good_frames is unchanged, and lock is reacquired within 1 frame + 3 lines.
- After lock, vsync fall at line 520 of 521: err_vlen pulses, state returns to SEARCH, pix_valid=0 until re-lock.
- hsync low for 95 clocks while locked: err_hlen pulses at h=95.
- clr held for 1 cycle mid-frame while locked: the next cycle shows locked=0, good_frames=0 and all outputs at reset values. The bench then re-locks normally.
